// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame size, FSM encodings and parity helper.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    CONS_IDLE,
    CONS_VALID,
    CONS_WAIT
  } cons_state_e;

  // A frame is good when data plus parity bit carries an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous FIFO with registered occupancy; DEPTH must be a power of two.
// Shared by the keyboard and (future) mouse receive channels.
module ps2_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign fill  = cnt_q;
  assign head  = mem_q[rd_ptr_q];

  // NOTE: every output of an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    do_push  = en & push & ~full;
    do_pop   = en & pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define what is valid, so it can map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ps2_rx_param.sv
// PS/2 device-to-host receiver: clock deglitch, frame check, FIFO, valid/ack handshake.
// Optional partial-frame timeout enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_param
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clock_25m,
  input  logic                          reset_25m_n,
  input  logic                          clock_valid,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DAT,
  input  logic                          ack,
  output logic [7:0]                    data,
  output logic                          valid,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int DATA_BITS = PS2_FRAME_BITS - 3;

  // Synchronisers run every cycle so clock_valid gaps never widen metastability windows.
  logic [1:0] clk_sync_q, dat_sync_q;
  logic       clk_s, dat_s;

  always_ff @(posedge clock_25m or negedge reset_25m_n) begin
    if (!reset_25m_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
    end
  end

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  logic [FILTER_LEN-1:0] flt_q, flt_d;
  logic                  filt_q, filt_d;
  logic                  fall;

  always_comb begin
    flt_d  = flt_q;
    filt_d = filt_q;
    fall   = 1'b0;
    if (clock_valid) begin
      flt_d = {flt_q[FILTER_LEN-2:0], clk_s};
      if (flt_q == '0)  filt_d = 1'b0;
      else if (&flt_q)  filt_d = 1'b1;
      fall = filt_q & ~filt_d;
    end
  end

  logic timeout_hit;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          rise;
  rx_state_e     rx_state_q;

  always_comb begin
    to_cnt_d    = to_cnt_q;
    timeout_hit = 1'b0;
    rise        = clock_valid & ~filt_q & filt_d;
    if (clock_valid) begin
      if (fall || rise || rx_state_q == RX_IDLE) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout_hit = 1'b1;
        to_cnt_d    = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clock_25m or negedge reset_25m_n) begin
    if (!reset_25m_n) to_cnt_q <= '0;
    else              to_cnt_q <= to_cnt_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  rx_state_e rx_state_q;

  assign timeout_hit = 1'b0;
`endif

  rx_state_e rx_state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] byte_q, byte_d;
  logic       par_q, par_d;
  logic       push, perr_set, ferr_set, ovf_set;
  logic       perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic       fifo_full, fifo_empty, pop;
  logic [7:0] fifo_head;

  always_comb begin
    rx_state_d = rx_state_q;
    bitcnt_d   = bitcnt_q;
    byte_d     = byte_q;
    par_d      = par_q;
    push       = 1'b0;
    perr_set   = 1'b0;
    ferr_set   = 1'b0;
    ovf_set    = 1'b0;
    if (fall) begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!dat_s) begin
            rx_state_d = RX_DATA;
            bitcnt_d   = '0;
          end
        end
        RX_DATA: begin
          byte_d   = {dat_s, byte_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'(DATA_BITS - 1)) rx_state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d      = dat_s;
          rx_state_d = RX_STOP;
        end
        RX_STOP: begin
          // A bad stop bit outranks bad parity: report framing only.
          if (!dat_s)                         ferr_set = 1'b1;
          else if (!odd_parity(byte_q, par_q)) perr_set = 1'b1;
          else if (fifo_full)                  ovf_set  = 1'b1;
          else                                 push     = 1'b1;
          rx_state_d = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end else if (timeout_hit) begin
      rx_state_d = RX_IDLE;
      ferr_set   = 1'b1;
    end
    // Pulses hold across disabled cycles so each lasts one enabled cycle.
    perr_d = clock_valid ? perr_set : perr_q;
    ferr_d = clock_valid ? ferr_set : ferr_q;
    ovf_d  = clock_valid ? ovf_set  : ovf_q;
  end

  cons_state_e cons_q, cons_d;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;

  always_comb begin
    cons_d  = cons_q;
    valid_d = valid_q;
    data_d  = data_q;
    pop     = 1'b0;
    if (clock_valid) begin
      case (cons_q)
        CONS_IDLE: begin
          if (!fifo_empty) begin
            cons_d  = CONS_VALID;
            valid_d = 1'b1;
            data_d  = fifo_head;
          end
        end
        CONS_VALID: begin
          if (ack) begin
            pop     = 1'b1;
            cons_d  = CONS_WAIT;
            valid_d = 1'b0;
          end
        end
        CONS_WAIT: begin
          if (!ack) cons_d = CONS_IDLE;
        end
        default: begin
          cons_d  = CONS_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_25m or negedge reset_25m_n) begin
    if (!reset_25m_n) begin
      flt_q      <= '1;
      filt_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      bitcnt_q   <= '0;
      byte_q     <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cons_q     <= CONS_IDLE;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      flt_q      <= flt_d;
      filt_q     <= filt_d;
      rx_state_q <= rx_state_d;
      bitcnt_q   <= bitcnt_d;
      byte_q     <= byte_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
      cons_q     <= cons_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  ps2_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock_25m),
    .rst_n (reset_25m_n),
    .en    (clock_valid),
    .push  (push),
    .pop   (pop),
    .din   (byte_q),
    .head  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .fill  (fill)
  );

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_param.sv
// Self-checking bench for ps2_rx_param: table-driven frames plus reset/glitch/timeout sequences.
module tb_ps2_rx_param;
  import ps2_pkg::*;

  localparam int FILTER_LEN = 8;
  localparam int DEPTH      = 4;
  localparam int TIMEOUT    = 1000;
  localparam int HALF       = 20;

  logic       clock_25m = 1'b0;
  logic       reset_25m_n;
  logic       clock_valid;
  logic       PS2_CLK, PS2_DAT, ack;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, overflow;
  logic [$clog2(DEPTH):0] fill;

  int checks = 0;
  int errors = 0;
  int pe_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  logic [7:0] exp_q[$];

  ps2_rx_param #(
    .FILTER_LEN     (FILTER_LEN),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock_25m   (clock_25m),
    .reset_25m_n (reset_25m_n),
    .clock_valid (clock_valid),
    .PS2_CLK     (PS2_CLK),
    .PS2_DAT     (PS2_DAT),
    .ack         (ack),
    .data        (data),
    .valid       (valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .fill        (fill)
  );

  always #20 clock_25m = ~clock_25m;

  always @(negedge clock_25m) begin
    if (parity_err) pe_cnt++;
    if (frame_err)  fe_cnt++;
    if (overflow)   ov_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_bit,
                            input int nbits, input bit glitch);
    logic [PS2_FRAME_BITS-1:0] f;
    f = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DAT = f[i];
      if (glitch) begin
        repeat (12) @(negedge clock_25m);
        PS2_CLK = 1'b0;
        repeat (3) @(negedge clock_25m);
        PS2_CLK = 1'b1;
        repeat (HALF - 15) @(negedge clock_25m);
      end else begin
        repeat (HALF) @(negedge clock_25m);
      end
      PS2_CLK = 1'b0;
      repeat (HALF) @(negedge clock_25m);
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    repeat (HALF) @(negedge clock_25m);
  endtask

  task automatic drain_one();
    int n;
    logic [7:0] exp_b;
    n = 0;
    while (!valid && n < 200) begin
      @(negedge clock_25m);
      n++;
    end
    check("valid_offered", valid, 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
      return;
    end
    exp_b = exp_q.pop_front();
    check("data", data, exp_b);
    ack = 1'b1;
    @(negedge clock_25m);
    check("valid_drop_after_ack", valid, 0);
    check("fill_after_pop", fill, exp_q.size());
    ack = 1'b0;
    repeat (2) @(negedge clock_25m);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         stop;
    bit         exp_pe;
    bit         exp_fe;
    bit         drain;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int pe0, fe0, ov0, n;
    bit good, exp_ov;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    reset_25m_n = 1'b0;
    clock_valid = 1'b1;
    PS2_CLK     = 1'b1;
    PS2_DAT     = 1'b1;
    ack         = 1'b0;
    repeat (3) @(negedge clock_25m);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_fill", fill, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    reset_25m_n = 1'b1;
    repeat (20) @(negedge clock_25m);

    for (int i = 0; i < 9; i++) begin
      pe0    = pe_cnt;
      fe0    = fe_cnt;
      ov0    = ov_cnt;
      good   = vecs[i].stop && !vecs[i].bad_par;
      exp_ov = 1'b0;
      if (good) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(vecs[i].b);
        else                      exp_ov = 1'b1;
      end
      send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].stop, PS2_FRAME_BITS, 1'b0);
      repeat (4) @(negedge clock_25m);
      check($sformatf("v%0d_parity_err", i), pe_cnt - pe0, vecs[i].exp_pe);
      check($sformatf("v%0d_frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
      check($sformatf("v%0d_overflow", i), ov_cnt - ov0, exp_ov);
      check($sformatf("v%0d_fill", i), fill, exp_q.size());
      check($sformatf("v%0d_valid", i), valid, exp_q.size() != 0);
      if (vecs[i].drain)
        while (exp_q.size() != 0) drain_one();
    end

    // Low glitches shorter than the filter inside every high phase.
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b0, 1'b1, PS2_FRAME_BITS, 1'b1);
    repeat (4) @(negedge clock_25m);
    check("glitch_fill", fill, 1);
    drain_one();

    // Reset while a byte is offered and another frame is half received.
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b0, 1'b1, PS2_FRAME_BITS, 1'b0);
    repeat (4) @(negedge clock_25m);
    check("pre_reset_valid", valid, 1);
    send_frame(8'h44, 1'b0, 1'b1, 5, 1'b0);
    reset_25m_n = 1'b0;
    #1;
    check("midreset_valid", valid, 0);
    check("midreset_fill", fill, 0);
    check("midreset_data", data, 0);
    exp_q.delete();
    repeat (3) @(negedge clock_25m);
    reset_25m_n = 1'b1;
    repeat (20) @(negedge clock_25m);
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b0, 1'b1, PS2_FRAME_BITS, 1'b0);
    repeat (4) @(negedge clock_25m);
    check("post_reset_fill", fill, 1);
    drain_one();

`ifdef PS2_RX_TIMEOUT_EN
    // Start bit plus three data bits, then the clock stops.
    fe0 = fe_cnt;
    send_frame(8'h00, 1'b0, 1'b1, 4, 1'b0);
    n = 0;
    while (fe_cnt == fe0 && n < 1500) begin
      @(negedge clock_25m);
      n++;
    end
    check("timeout_frame_err", fe_cnt - fe0, 1);
    check("timeout_latency_window", (n > 950 && n < 1020), 1);
    check("timeout_fill", fill, 0);
    exp_q.push_back(8'h29);
    send_frame(8'h29, 1'b0, 1'b1, PS2_FRAME_BITS, 1'b0);
    repeat (4) @(negedge clock_25m);
    check("after_timeout_fill", fill, 1);
    drain_one();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
